// File: rtl/imem_fetch_ctrl_if.sv
// rtl/imem_fetch_ctrl_if.sv - instruction bus request/response bundle
interface imem_fetch_ctrl_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
);
  logic                   imem_req;
  logic [ADDR_WIDTH-1:0]  imem_addr;
  logic                   imem_gnt;
  logic                   imem_rvalid;
  logic [INSTR_WIDTH-1:0] imem_rdata;
  logic                   imem_err;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata, imem_err
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata, imem_err
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - in-order instruction fetch request controller; hold buffer enabled by KRV_IFB_HOLD_EN
module imem_fetch_ctrl #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int OUTSTANDING = 2
) (
  input  logic                   cpu_clk,
  input  logic                   cpu_rstn,
  input  logic [ADDR_WIDTH-1:0]  next_pc,
  input  logic [ADDR_WIDTH-1:0]  pc,
  input  logic                   ifb_flush,
  output logic                   instr_read_data_valid,
  output logic [INSTR_WIDTH-1:0] instr_read_data,
  output logic                   instr_fault,
  imem_fetch_ctrl_if.master      imem
);
  localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(OUTSTANDING) + 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OUTSTANDING);

  // in-flight address tracking, one entry per granted-but-unanswered request
  logic [ADDR_WIDTH-1:0]  fifo_addr [OUTSTANDING];
  logic [OUTSTANDING-1:0] fifo_vld;
  logic [OUTSTANDING-1:0] fifo_stale;
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       wr_ptr;
  logic [CNT_W-1:0]       count;
  logic                   started;

  logic                   grant;
  logic                   pop;
  logic [ADDR_WIDTH-1:0]  head_addr;
  logic                   head_stale;
  logic                   resp_live;
  logic                   bus_hit;
  logic                   hold_hit;
  logic                   blocked;
  logic                   fifo_cov;
  logic                   resp_cov;
  logic                   hold_cov;
  logic                   covered;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign grant      = imem.imem_req && imem.imem_gnt;
  // a response with nothing outstanding is a protocol error and is ignored
  assign pop        = imem.imem_rvalid && (count != '0);
  assign head_addr  = fifo_addr[rd_ptr];
  assign head_stale = fifo_stale[rd_ptr];
  // a response is usable only if its entry survived every flush, including this cycle's
  assign resp_live  = pop && !head_stale && !ifb_flush;
  assign bus_hit    = resp_live && (head_addr == pc);

  assign blocked    = (count == CNT_FULL) && !imem.imem_rvalid;
  assign covered    = fifo_cov || resp_cov || hold_cov;

  // started keeps the request low for the first cycle out of reset
  assign imem.imem_req  = started && !blocked && !covered;
  assign imem.imem_addr = next_pc;

  // does an outstanding, still-useful entry already fetch next_pc
  always_comb begin
    fifo_cov = 1'b0;
    for (int i = 0; i < OUTSTANDING; i++) begin
      if (fifo_vld[i] && !fifo_stale[i] && (fifo_addr[i] == next_pc) &&
          !(pop && (rd_ptr == PTR_W'(i))))
        fifo_cov = 1'b1;
    end
  end

  // FIFO pointers, occupancy and stale marking; a push wins over a pop on the same slot
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      fifo_vld   <= '0;
      fifo_stale <= '0;
      started    <= 1'b0;
    end else begin
      started <= 1'b1;
      count   <= count + CNT_W'(grant) - CNT_W'(pop);
      if (ifb_flush)
        fifo_stale <= '1;
      if (pop) begin
        fifo_vld[rd_ptr] <= 1'b0;
        rd_ptr           <= ptr_inc(rd_ptr);
      end
      if (grant) begin
        fifo_vld[wr_ptr]   <= 1'b1;
        fifo_stale[wr_ptr] <= ifb_flush;
        wr_ptr             <= ptr_inc(wr_ptr);
      end
    end
  end

  // FIFO address storage; contents are meaningless until the matching valid bit is set
  always_ff @(posedge cpu_clk) begin
    if (grant)
      fifo_addr[wr_ptr] <= imem.imem_addr;
  end

`ifdef KRV_IFB_HOLD_EN
  logic                   hold_valid;
  logic [ADDR_WIDTH-1:0]  hold_addr;
  logic [INSTR_WIDTH-1:0] hold_data;
  logic                   hold_err;

  // hold buffer keeps the last live response so a stalled pc needs no re-fetch
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      hold_valid <= 1'b0;
      hold_addr  <= '0;
      hold_data  <= '0;
      hold_err   <= 1'b0;
    end else if (ifb_flush) begin
      hold_valid <= 1'b0;
    end else if (resp_live) begin
      hold_valid <= 1'b1;
      hold_addr  <= head_addr;
      hold_data  <= imem.imem_rdata;
      hold_err   <= imem.imem_err;
    end
  end

  assign hold_hit = hold_valid && (hold_addr == pc);
  assign resp_cov = resp_live && (head_addr == next_pc);
  assign hold_cov = hold_valid && !ifb_flush && (hold_addr == next_pc);
`else
  assign hold_hit = 1'b0;
  assign resp_cov = 1'b0;
  assign hold_cov = 1'b0;
`endif

  // return the instruction for pc, bus response taking priority over the hold copy
  always_comb begin
    instr_read_data_valid = bus_hit || hold_hit;
    instr_read_data       = '0;
    instr_fault           = 1'b0;
    if (bus_hit) begin
      instr_read_data = imem.imem_rdata;
      instr_fault     = imem.imem_err;
    end
`ifdef KRV_IFB_HOLD_EN
    else if (hold_hit) begin
      instr_read_data = hold_data;
      instr_fault     = hold_err;
    end
`endif
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb/tb_imem_fetch_ctrl.sv - directed bench for imem_fetch_ctrl
module tb_imem_fetch_ctrl;
  localparam logic O = 1'b0;
  localparam logic I = 1'b1;

  typedef struct packed {
    logic        rstn;
    logic [31:0] npc;
    logic [31:0] pc;
    logic        gnt;
    logic        rv;
    logic [31:0] rd;
    logic        err;
    logic        fl;
    logic        ereq;
    logic        evld;
    logic [31:0] edata;
    logic        efault;
  } row_t;

  logic        cpu_clk;
  logic        cpu_rstn;
  logic [31:0] next_pc;
  logic [31:0] pc;
  logic        ifb_flush;
  logic        instr_read_data_valid;
  logic [31:0] instr_read_data;
  logic        instr_fault;

  int n_checks;
  int n_fail;

  imem_fetch_ctrl_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(32)) bus ();

  imem_fetch_ctrl #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .OUTSTANDING(2)) dut (
    .cpu_clk               (cpu_clk),
    .cpu_rstn              (cpu_rstn),
    .next_pc               (next_pc),
    .pc                    (pc),
    .ifb_flush             (ifb_flush),
    .instr_read_data_valid (instr_read_data_valid),
    .instr_read_data       (instr_read_data),
    .instr_fault           (instr_fault),
    .imem                  (bus)
  );

  initial begin
    cpu_clk = 1'b0;
    forever #5 cpu_clk = ~cpu_clk;
  end

  function automatic row_t mk(input logic rstn, input logic [31:0] npc, input logic [31:0] cpc,
                              input logic gnt, input logic rv, input logic [31:0] rd,
                              input logic err, input logic fl, input logic ereq,
                              input logic evld, input logic [31:0] edata, input logic efault);
    return '{rstn, npc, cpc, gnt, rv, rd, err, fl, ereq, evld, edata, efault};
  endfunction

  task automatic apply(input row_t r);
    cpu_rstn        = r.rstn;
    next_pc         = r.npc;
    pc              = r.pc;
    bus.imem_gnt    = r.gnt;
    bus.imem_rvalid = r.rv;
    bus.imem_rdata  = r.rd;
    bus.imem_err    = r.err;
    ifb_flush       = r.fl;
  endtask

  task automatic do_reset();
    @(negedge cpu_clk);
    apply(mk(O, 32'h0, 32'h0, O, O, 32'h0, O, O, O, O, 32'h0, O));
    @(negedge cpu_clk);
    cpu_rstn = 1'b1;
  endtask

  task automatic test_reset();
    row_t t[$];
    t.push_back(mk(O, 32'h0,  32'h0, I, I, 32'hFFFF, I, O, O, O, 32'h0,    O));
    t.push_back(mk(I, 32'h0,  32'h0, I, I, 32'hFFFF, I, O, O, O, 32'h0,    O));
    t.push_back(mk(I, 32'h0,  32'h0, I, O, 32'h0,    O, O, I, O, 32'h0,    O));
    t.push_back(mk(I, 32'h4,  32'h0, I, I, 32'h13,   O, O, I, I, 32'h13,   O));
    t.push_back(mk(I, 32'h8,  32'h4, I, I, 32'h1111, O, O, I, I, 32'h1111, O));
    t.push_back(mk(I, 32'hC,  32'h8, I, I, 32'h2222, O, O, I, I, 32'h2222, O));
    t.push_back(mk(I, 32'h10, 32'hC, O, I, 32'h3333, O, O, I, I, 32'h3333, O));
    foreach (t[i]) begin
      @(negedge cpu_clk); apply(t[i]); #1;
      n_checks++;
      if ({bus.imem_req, instr_read_data_valid, instr_read_data, instr_fault} !==
          {t[i].ereq, t[i].evld, t[i].edata, t[i].efault}) begin
        n_fail++;
        $display("FAIL reset_first_fetch[%0d] req/valid/data/fault got %b/%b/%h/%b want %b/%b/%h/%b", i,
                 bus.imem_req, instr_read_data_valid, instr_read_data, instr_fault,
                 t[i].ereq, t[i].evld, t[i].edata, t[i].efault);
      end
    end
  endtask

  task automatic test_jump();
    row_t t[$];
    do_reset();
    t.push_back(mk(I, 32'h10,  32'h0C,  I, O, 32'h0,    O, O, I, O, 32'h0,    O));
    t.push_back(mk(I, 32'h14,  32'h10,  I, O, 32'h0,    O, O, I, O, 32'h0,    O));
    t.push_back(mk(I, 32'h100, 32'h200, O, O, 32'h0,    O, O, O, O, 32'h0,    O));
    t.push_back(mk(I, 32'h100, 32'h100, I, I, 32'hAAAA, O, O, I, O, 32'h0,    O));
    t.push_back(mk(I, 32'h100, 32'h100, O, I, 32'hBBBB, O, O, O, O, 32'h0,    O));
    t.push_back(mk(I, 32'h104, 32'h100, I, I, 32'hCCCC, O, O, I, I, 32'hCCCC, O));
    t.push_back(mk(I, 32'h108, 32'h104, O, I, 32'hDDDD, O, O, I, I, 32'hDDDD, O));
    foreach (t[i]) begin
      @(negedge cpu_clk); apply(t[i]); #1;
      n_checks++;
      if ({bus.imem_req, instr_read_data_valid, instr_read_data, instr_fault} !==
          {t[i].ereq, t[i].evld, t[i].edata, t[i].efault}) begin
        n_fail++;
        $display("FAIL jump[%0d] req/valid/data/fault got %b/%b/%h/%b want %b/%b/%h/%b", i,
                 bus.imem_req, instr_read_data_valid, instr_read_data, instr_fault,
                 t[i].ereq, t[i].evld, t[i].edata, t[i].efault);
      end
    end
  endtask

  task automatic test_stall();
    row_t t[$];
    do_reset();
    t.push_back(mk(I, 32'h20, 32'h1C, I, O, 32'h0,    O, O, I, O, 32'h0,    O));
`ifdef KRV_IFB_HOLD_EN
    t.push_back(mk(I, 32'h20, 32'h20, I, I, 32'h5555, O, O, O, I, 32'h5555, O));
    t.push_back(mk(I, 32'h20, 32'h20, I, O, 32'h0,    O, O, O, I, 32'h5555, O));
    t.push_back(mk(I, 32'h20, 32'h20, I, O, 32'h0,    O, O, O, I, 32'h5555, O));
    t.push_back(mk(I, 32'h20, 32'h20, I, O, 32'h0,    O, O, O, I, 32'h5555, O));
    t.push_back(mk(I, 32'h24, 32'h20, O, O, 32'h0,    O, O, I, I, 32'h5555, O));
`else
    t.push_back(mk(I, 32'h20, 32'h20, I, I, 32'h5555, O, O, I, I, 32'h5555, O));
    t.push_back(mk(I, 32'h20, 32'h20, O, O, 32'h0,    O, O, O, O, 32'h0,    O));
    t.push_back(mk(I, 32'h20, 32'h20, O, O, 32'h0,    O, O, O, O, 32'h0,    O));
    t.push_back(mk(I, 32'h24, 32'h20, O, I, 32'h5555, O, O, I, I, 32'h5555, O));
`endif
    foreach (t[i]) begin
      @(negedge cpu_clk); apply(t[i]); #1;
      n_checks++;
      if ({bus.imem_req, instr_read_data_valid, instr_read_data, instr_fault} !==
          {t[i].ereq, t[i].evld, t[i].edata, t[i].efault}) begin
        n_fail++;
        $display("FAIL stall[%0d] req/valid/data/fault got %b/%b/%h/%b want %b/%b/%h/%b", i,
                 bus.imem_req, instr_read_data_valid, instr_read_data, instr_fault,
                 t[i].ereq, t[i].evld, t[i].edata, t[i].efault);
      end
    end
  endtask

  task automatic test_full_fifo();
    row_t t[$];
    do_reset();
    t.push_back(mk(I, 32'h200, 32'h1FC, I, O, 32'h0,    O, O, I, O, 32'h0,    O));
    t.push_back(mk(I, 32'h204, 32'h200, I, O, 32'h0,    O, O, I, O, 32'h0,    O));
    t.push_back(mk(I, 32'h208, 32'h200, I, O, 32'h0,    O, O, O, O, 32'h0,    O));
    t.push_back(mk(I, 32'h208, 32'h200, I, O, 32'h0,    O, O, O, O, 32'h0,    O));
    t.push_back(mk(I, 32'h208, 32'h200, I, O, 32'h0,    O, O, O, O, 32'h0,    O));
    t.push_back(mk(I, 32'h208, 32'h200, I, I, 32'h6666, O, O, I, I, 32'h6666, O));
    t.push_back(mk(I, 32'h20C, 32'h204, O, I, 32'h7777, O, O, I, I, 32'h7777, O));
    t.push_back(mk(I, 32'h20C, 32'h208, O, I, 32'h8888, O, O, I, I, 32'h8888, O));
    foreach (t[i]) begin
      @(negedge cpu_clk); apply(t[i]); #1;
      n_checks++;
      if ({bus.imem_req, instr_read_data_valid, instr_read_data, instr_fault} !==
          {t[i].ereq, t[i].evld, t[i].edata, t[i].efault}) begin
        n_fail++;
        $display("FAIL full_fifo[%0d] req/valid/data/fault got %b/%b/%h/%b want %b/%b/%h/%b", i,
                 bus.imem_req, instr_read_data_valid, instr_read_data, instr_fault,
                 t[i].ereq, t[i].evld, t[i].edata, t[i].efault);
      end
    end
  endtask

  task automatic test_flush();
    row_t t[$];
    do_reset();
    t.push_back(mk(I, 32'h40, 32'h3C, I, O, 32'h0,    O, O, I, O, 32'h0,    O));
    t.push_back(mk(I, 32'h40, 32'h40, I, O, 32'h0,    O, I, O, O, 32'h0,    O));
    t.push_back(mk(I, 32'h40, 32'h40, I, I, 32'h9999, O, O, I, O, 32'h0,    O));
    t.push_back(mk(I, 32'h44, 32'h40, O, I, 32'h9999, O, O, I, I, 32'h9999, O));
    t.push_back(mk(I, 32'h40, 32'h44, O, O, 32'h0,    O, I, I, O, 32'h0,    O));
    t.push_back(mk(I, 32'h40, 32'h40, I, O, 32'h0,    O, I, I, O, 32'h0,    O));
    t.push_back(mk(I, 32'h40, 32'h40, O, I, 32'h1234, O, O, I, O, 32'h0,    O));
    t.push_back(mk(I, 32'h40, 32'h40, I, O, 32'h0,    O, O, I, O, 32'h0,    O));
    t.push_back(mk(I, 32'h44, 32'h40, O, I, 32'h4321, O, I, I, O, 32'h0,    O));
    t.push_back(mk(I, 32'h44, 32'h40, O, O, 32'h0,    O, O, I, O, 32'h0,    O));
    foreach (t[i]) begin
      @(negedge cpu_clk); apply(t[i]); #1;
      n_checks++;
      if ({bus.imem_req, instr_read_data_valid, instr_read_data, instr_fault} !==
          {t[i].ereq, t[i].evld, t[i].edata, t[i].efault}) begin
        n_fail++;
        $display("FAIL flush[%0d] req/valid/data/fault got %b/%b/%h/%b want %b/%b/%h/%b", i,
                 bus.imem_req, instr_read_data_valid, instr_read_data, instr_fault,
                 t[i].ereq, t[i].evld, t[i].edata, t[i].efault);
      end
    end
  endtask

  task automatic test_bus_error();
    row_t t[$];
    do_reset();
    t.push_back(mk(I, 32'h80, 32'h7C, I, O, 32'h0,        O, O, I, O, 32'h0,        O));
    t.push_back(mk(I, 32'h84, 32'h80, O, I, 32'hDEADBEEF, I, O, I, I, 32'hDEADBEEF, I));
    t.push_back(mk(I, 32'h84, 32'h84, I, O, 32'h0,        O, O, I, O, 32'h0,        O));
    t.push_back(mk(I, 32'h88, 32'h84, O, I, 32'h13,       O, O, I, I, 32'h13,       O));
    foreach (t[i]) begin
      @(negedge cpu_clk); apply(t[i]); #1;
      n_checks++;
      if ({bus.imem_req, instr_read_data_valid, instr_read_data, instr_fault} !==
          {t[i].ereq, t[i].evld, t[i].edata, t[i].efault}) begin
        n_fail++;
        $display("FAIL bus_error[%0d] req/valid/data/fault got %b/%b/%h/%b want %b/%b/%h/%b", i,
                 bus.imem_req, instr_read_data_valid, instr_read_data, instr_fault,
                 t[i].ereq, t[i].evld, t[i].edata, t[i].efault);
      end
    end
  endtask

  task automatic test_reset_mid();
    row_t t[$];
    do_reset();
    t.push_back(mk(I, 32'h300, 32'h2FC, I, O, 32'h0,    O, O, I, O, 32'h0,    O));
    t.push_back(mk(O, 32'h300, 32'h300, I, O, 32'h0,    O, O, O, O, 32'h0,    O));
    t.push_back(mk(I, 32'h300, 32'h300, I, I, 32'h5A5A, O, O, O, O, 32'h0,    O));
    t.push_back(mk(I, 32'h300, 32'h300, I, O, 32'h0,    O, O, I, O, 32'h0,    O));
    t.push_back(mk(I, 32'h304, 32'h300, O, I, 32'h5A5A, O, O, I, I, 32'h5A5A, O));
    foreach (t[i]) begin
      @(negedge cpu_clk); apply(t[i]); #1;
      n_checks++;
      if ({bus.imem_req, instr_read_data_valid, instr_read_data, instr_fault} !==
          {t[i].ereq, t[i].evld, t[i].edata, t[i].efault}) begin
        n_fail++;
        $display("FAIL reset_mid[%0d] req/valid/data/fault got %b/%b/%h/%b want %b/%b/%h/%b", i,
                 bus.imem_req, instr_read_data_valid, instr_read_data, instr_fault,
                 t[i].ereq, t[i].evld, t[i].edata, t[i].efault);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    apply(mk(O, 32'h0, 32'h0, O, O, 32'h0, O, O, O, O, 32'h0, O));
    test_reset();
    test_jump();
    test_stall();
    test_full_fifo();
    test_flush();
    test_bus_error();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Instruction-memory fetch controller sitting directly upstream of the fetch stage. Turns the fetch stage's combinational `next_pc` into pipelined, in-order requests on the instruction bus. Tracks up to `OUTSTANDING` in-flight addresses and returns `instr_read_data_valid` / `instr_read_data` only when a response belongs to the fetch stage's current `pc`. Stale responses left behind by jumps, traps or mispredicts are dropped silently; a one-entry hold buffer covers fetch stalls.

## Interface
- `ADDR_WIDTH`, 32, address width
- `INSTR_WIDTH`, 32, instruction width
- `OUTSTANDING`, 2, maximum granted-but-unanswered requests (power of two, ≥1)

Ports:
- `cpu_clk`  in  1  CPU clock; the block's only clock
- `cpu_rstn`  in  1  reset, asynchronous assert, active low
- `next_pc`  in  ADDR_WIDTH  address fetch will hold in `pc` next cycle
- `pc`  in  ADDR_WIDTH  fetch stage's current PC
- `ifb_flush`  in  1  invalidate hold buffer and mark all in-flight entries stale (fence)
- `instr_read_data_valid`  out  1  `instr_read_data` is the instruction at `pc` this cycle
- `instr_read_data`  out  INSTR_WIDTH  instruction; 0 when not valid
- `instr_fault`  out  1  bus error for the instruction at `pc`; qualified by valid
- `imem_req`  out  1  request
- `imem_addr`  out  ADDR_WIDTH  request address, always equal to `next_pc`
- `imem_gnt`  in  1  request accepted this cycle
- `imem_rvalid`  in  1  response valid
- `imem_rdata`  in  INSTR_WIDTH  response data
- `imem_err`  in  1  response error, qualified by `imem_rvalid`

## Operation
- **Bus rules**
  - A transfer is accepted on `imem_req && imem_gnt`.
  - Responses return in order, at least 1 cycle after the grant, one response per grant.
  - `imem_addr` may change while `imem_req` is high and ungranted.
- **Address FIFO**
  - Depth `OUTSTANDING`. Each entry holds {addr, stale}.
  - Push on grant; pop on `imem_rvalid`. Push and pop in the same cycle are legal at full.
  - Count width is clog2(OUTSTANDING)+1.
  - `imem_rvalid` with the FIFO empty is a protocol error and is ignored.
  - `ifb_flush` sets stale on every entry, including one pushed that cycle.
- **Hit detection**
  - Bus hit: `imem_rvalid` && head not stale && head.addr == `pc`.
  - Hold hit: hold.valid && hold.addr == `pc`.
  - A bus hit takes priority over a hold hit. Valid = bus hit || hold hit.
  - Data and fault come from the winning source; both are 0 when neither hits.
- **Hold buffer**
  - Loaded with {addr, data, err} on every non-stale response, whether or not it hits.
  - Cleared by `ifb_flush`.
- **Issue**
  - `imem_req` = !blocked && !covered.
  - blocked: count == OUTSTANDING && !`imem_rvalid`.
  - covered: any of the following match `next_pc`:
    - a non-stale FIFO entry not popping this cycle;
    - the non-stale response arriving this cycle;
    - the hold buffer, unless it is being flushed.
- **Stale drop**: a popped entry that is stale, or whose addr ≠ `pc`, produces no valid. The hold load still occurs if the entry is non-stale.
- **Misalignment**: none; fetch reports misaligned PCs. The block issues whatever `next_pc` holds.

## Timing
- **Reset values**: `imem_req`=0, `instr_read_data_valid`=0, `instr_read_data`=0, `instr_fault`=0, FIFO empty, hold invalid.
- **Latency**: request at cycle t, zero-wait slave → `instr_read_data_valid`=1 at t+1, combinational from `imem_rvalid`.
- **Sustained rate**: 1 instruction/cycle with a zero-wait slave and `OUTSTANDING` ≥ 1.
- **Simultaneous events**
  - `ifb_flush` with a response in the same cycle: that response is dropped and not held.
  - Flush with a grant in the same cycle: the new entry is stale.
  - Reset mid-transaction: FIFO cleared. Responses arriving after reset with an empty FIFO are ignored.

## Configuration
- `KRV_IFB_HOLD_EN` defined: hold buffer present, as described above.
- `KRV_IFB_HOLD_EN` undefined:
  - No hold buffer; only bus hits produce valid.
  - covered considers in-flight FIFO entries only.
  - A stalled `pc` re-requests once its response has been consumed.

## Test plan
- **Reset / first fetch**: `boot_addr` 0x0000_0000, zero-wait slave returning 0x0000_0013 → req at cycle 1 after reset, valid=1 with data 0x13 at cycle 2, then one instruction/cycle for 0x4, 0x8, …
- **Jump drops stale data**: entries 0x10/0x14 in flight, `next_pc`→0x100 → responses for 0x10/0x14 produce no valid; 0x100 valid 1 cycle after its response.
- **Stall with hold**: `pc` held at 0x20 for 3 cycles after its response → valid=1 every cycle, no re-request (`KRV_IFB_HOLD_EN`). Without the macro: one re-request, valid only on response cycles.
- **Full FIFO**: `OUTSTANDING`=2, `imem_rvalid` withheld 4 cycles → exactly 2 grants, `imem_req`=0 until the first response; simultaneous pop + push accepted.
- **Flush**: `ifb_flush` with 0x40 in flight and `pc`=0x40 → the 0x40 response is dropped, hold invalid, 0x40 re-requested next cycle.
- **Bus error**: response for `pc` 0x80 with `imem_err`=1 → valid=1, `instr_fault`=1, data = `imem_rdata`.
